// File: rtl/freq_div_arb_pkg.sv
// Shared types and helpers for the frequency-divider arbiter.
// Optional feature: FDA_TIMEOUT_EN (see freq_div_arbiter.sv).
package freq_div_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT  = 2'd1,
      S_SWITCH = 2'd2,
      S_DWELL  = 2'd3
   } state_e;

   localparam int FDA_DEFAULT_SEL = 0;

   localparam int BUS_MAX   = 256;
   localparam int SLICE_MAX = 32;

   // Slice idx of width w out of a packed per-requester bus.
   function automatic logic [SLICE_MAX-1:0] fda_slice(
      input logic [BUS_MAX-1:0] bus,
      input int                 idx,
      input int                 w
   );
      logic [BUS_MAX-1:0] sh;
      logic [BUS_MAX-1:0] mask;
      sh   = bus >> (idx * w);
      mask = (BUS_MAX'(1) << w) - BUS_MAX'(1);
      return SLICE_MAX'(sh & mask);
   endfunction

endpackage

// File: rtl/freq_div_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after
// the pointer wins; one-hot winner plus its index.
module rr_arbiter
   import freq_div_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NREQ-1:0]  win_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   int j;

   always_comb begin
      win_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = (int'(ptr_i) + i) % NREQ;
         if (!any_o && req_i[IDX_W'(j)]) begin
            any_o             = 1'b1;
            win_o[IDX_W'(j)]  = 1'b1;
            idx_o             = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/freq_div_arbiter.sv
// Round-robin sequencer sharing one divider select between requesters.
// Define FDA_TIMEOUT_EN to force the select after 2^TO_W-1 wrapless cycles.
module freq_div_arbiter
   import freq_div_arb_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int SEL_W       = 3,
   parameter int DWELL_W     = 8,
   parameter int DEFAULT_SEL = FDA_DEFAULT_SEL,
   parameter int TO_W        = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*SEL_W-1:0]   req_sel,
   input  logic [NREQ*DWELL_W-1:0] req_dwell,
   input  logic                    wrap,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         done,
   output logic [SEL_W-1:0]        fsel,
   output logic                    busy,
   output logic                    timeout
);

   localparam int IDX_W = $clog2(NREQ);

   if (NREQ < 2 || NREQ > 8 || TO_W < 2) begin : g_param_chk
      $error("freq_div_arbiter: bad parameter");
   end

   state_e             state_q;
   logic [NREQ-1:0]    gnt_q;
   logic [NREQ-1:0]    done_q;
   logic [SEL_W-1:0]   fsel_q;
   logic [SEL_W-1:0]   sel_q;
   logic [DWELL_W-1:0] cnt_q;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   ptr_q;

   logic [NREQ-1:0]    win;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   logic [SEL_W-1:0]   sel_d;
   logic [DWELL_W-1:0] dwell_raw;
   logic [DWELL_W-1:0] dwell_d;
   logic [IDX_W-1:0]   ptr_d;
   logic               held;

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req_i (req),
      .ptr_i (ptr_q),
      .win_o (win),
      .idx_o (win_idx),
      .any_o (win_any)
   );

   assign sel_d     = SEL_W'(fda_slice(BUS_MAX'(req_sel), int'(win_idx), SEL_W));
   assign dwell_raw = DWELL_W'(fda_slice(BUS_MAX'(req_dwell), int'(win_idx), DWELL_W));
   assign dwell_d   = (dwell_raw == '0) ? DWELL_W'(1) : dwell_raw;

   assign ptr_d = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
   assign held  = req[idx_q];

`ifdef FDA_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((2 ** TO_W) - 2);

   logic [TO_W-1:0] to_cnt_q;
   logic            timeout_q;

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         done_q    <= '0;
         fsel_q    <= SEL_W'(DEFAULT_SEL);
         sel_q     <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
`ifdef FDA_TIMEOUT_EN
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         done_q <= '0;
         unique case (state_q)
            S_IDLE: begin
               if (|req) state_q <= S_GRANT;
            end
            S_GRANT: begin
               if (win_any) begin
                  idx_q    <= win_idx;
                  sel_q    <= sel_d;
                  cnt_q    <= dwell_d;
                  gnt_q    <= win;
                  state_q  <= S_SWITCH;
`ifdef FDA_TIMEOUT_EN
                  to_cnt_q <= '0;
`endif
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_SWITCH: begin
               if (!held) begin
                  gnt_q   <= '0;
                  ptr_q   <= ptr_d;
                  state_q <= S_IDLE;
               end else if (wrap) begin
                  fsel_q  <= sel_q;
                  state_q <= S_DWELL;
               end
`ifdef FDA_TIMEOUT_EN
               // A stalled divider must not hold the grant forever.
               else if (to_cnt_q == TO_LAST) begin
                  fsel_q    <= sel_q;
                  timeout_q <= 1'b1;
                  state_q   <= S_DWELL;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
`endif
            end
            S_DWELL: begin
               if (!held) begin
                  gnt_q   <= '0;
                  ptr_q   <= ptr_d;
                  state_q <= S_IDLE;
               end else if (wrap) begin
                  if (cnt_q <= DWELL_W'(1)) begin
                     done_q  <= gnt_q;
                     gnt_q   <= '0;
                     ptr_q   <= ptr_d;
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt  = gnt_q;
   assign done = done_q;
   assign fsel = fsel_q;
   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_div_arbiter.sv
// Scoreboard bench for freq_div_arbiter: stimulus queues expected
// grant/done events, a negedge monitor pops and compares them.
module tb_freq_div_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [11:0] req_sel;
   logic [31:0] req_dwell;
   logic        wrap;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic [2:0]  fsel;
   logic        busy;
   logic        timeout;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int         cyc;
      logic [3:0] gnt;
      logic [3:0] done;
      logic [2:0] fsel;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        e;
   logic [3:0] prev_gnt = 4'b0;

   freq_div_arbiter #(
      .NREQ        (4),
      .SEL_W       (3),
      .DWELL_W     (8),
      .DEFAULT_SEL (0),
      .TO_W        (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_sel   (req_sel),
      .req_dwell (req_dwell),
      .wrap      (wrap),
      .gnt       (gnt),
      .done      (done),
      .fsel      (fsel),
      .busy      (busy),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) begin
         prev_gnt = gnt;
      end else if (gnt !== prev_gnt || done !== 4'b0) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: cyc=%0d gnt=%b done=%b fsel=%0d, none required",
                     cyc, gnt, done, fsel);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.gnt !== gnt || e.done !== done || e.fsel !== fsel) begin
               n_bad++;
               $display("FAIL event: got cyc=%0d gnt=%b done=%b fsel=%0d, required cyc=%0d gnt=%b done=%b fsel=%0d",
                        cyc, gnt, done, fsel, e.cyc, e.gnt, e.done, e.fsel);
            end
         end
         prev_gnt = gnt;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input int c, input logic [3:0] g, input logic [3:0] d,
                          input logic [2:0] f);
      ev_t ev;
      ev.cyc  = c;
      ev.gnt  = g;
      ev.done = d;
      ev.fsel = f;
      exp_q.push_back(ev);
   endtask

   task automatic pulse_wrap(input int gap, input bit push, input logic [3:0] dm,
                             input logic [2:0] f);
      repeat (gap) tick();
      if (push) push_ev(cyc + 1, 4'b0, dm, f);
      wrap = 1'b1;
      tick();
      wrap = 1'b0;
   endtask

   logic [2:0] pf;
   int         idx;

   initial begin
      reset     = 1'b1;
      req       = '0;
      req_sel   = '0;
      req_dwell = '0;
      wrap      = 1'b0;
      tick();
      tick();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_fsel", 32'(fsel), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_timeout", 32'(timeout), 0);
      reset = 1'b0;
      tick();

      // single request, wrap in GRANT ignored
      req_sel   = {3'd0, 3'd0, 3'd3, 3'd0};
      req_dwell = {8'd0, 8'd0, 8'd2, 8'd0};
      req       = 4'b0010;
      push_ev(cyc + 2, 4'b0010, 4'b0, 3'd0);
      tick();
      wrap = 1'b1;
      tick();
      wrap = 1'b0;
      chk("s1_busy", 32'(busy), 1);
      chk("s1_fsel_hold", 32'(fsel), 0);
      pulse_wrap(6, 1'b0, 4'b0, 3'd0);
      chk("s1_fsel_new", 32'(fsel), 3);
      pulse_wrap(7, 1'b0, 4'b0, 3'd0);
      pulse_wrap(7, 1'b1, 4'b0010, 3'd3);
      req = 4'b0;
      chk("s1_idle", 32'(busy), 0);
      tick();

      // fairness from a fresh pointer
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      req_sel   = {3'd7, 3'd6, 3'd5, 3'd4};
      req_dwell = {8'd1, 8'd1, 8'd1, 8'd1};
      req       = 4'b1111;
      pf        = 3'd0;
      for (int g = 0; g < 5; g++) begin
         idx = g % 4;
         push_ev(cyc + 2, 4'(1 << idx), 4'b0, pf);
         pulse_wrap(2, 1'b0, 4'b0, 3'd0);
         pulse_wrap(1, 1'b1, 4'(1 << idx), 3'(4 + idx));
         pf = 3'(4 + idx);
      end
      req = 4'b0;
      tick();

      // abandon req[2] after one dwell wrap; pointer then at 3
      req_dwell = {8'd1, 8'd3, 8'd1, 8'd1};
      req       = 4'b0100;
      push_ev(cyc + 2, 4'b0100, 4'b0, 3'd4);
      pulse_wrap(2, 1'b0, 4'b0, 3'd0);
      pulse_wrap(0, 1'b0, 4'b0, 3'd0);
      chk("ab_fsel", 32'(fsel), 6);
      push_ev(cyc + 1, 4'b0, 4'b0, 3'd6);
      req = 4'b0;
      tick();
      chk("ab_busy", 32'(busy), 0);
      chk("ab_fsel_kept", 32'(fsel), 6);
      req = 4'b1111;
      push_ev(cyc + 2, 4'b1000, 4'b0, 3'd6);
      pulse_wrap(2, 1'b0, 4'b0, 3'd0);
      pulse_wrap(1, 1'b1, 4'b1000, 3'd7);
      req = 4'b0;
      tick();

      // dwell 0 acts as 1
      req_sel   = {3'd7, 3'd6, 3'd3, 3'd1};
      req_dwell = {8'd1, 8'd1, 8'd2, 8'd0};
      req       = 4'b0001;
      push_ev(cyc + 2, 4'b0001, 4'b0, 3'd7);
      pulse_wrap(2, 1'b0, 4'b0, 3'd0);
      pulse_wrap(0, 1'b1, 4'b0001, 3'd1);
      req = 4'b0;
      tick();

      // async reset mid-DWELL
      req = 4'b0010;
      push_ev(cyc + 2, 4'b0010, 4'b0, 3'd1);
      pulse_wrap(2, 1'b0, 4'b0, 3'd0);
      tick();
      chk("pre_rst_fsel", 32'(fsel), 3);
      reset = 1'b1;
      req   = 4'b0;
      #1;
      chk("arst_fsel", 32'(fsel), 0);
      chk("arst_gnt", 32'(gnt), 0);
      chk("arst_busy", 32'(busy), 0);
      tick();
      reset = 1'b0;
      tick();

      // wrapless SWITCH: forced load only with the timeout build
      req_sel   = {3'd0, 3'd0, 3'd0, 3'd5};
      req_dwell = {8'd1, 8'd1, 8'd1, 8'd1};
      req       = 4'b0001;
      push_ev(cyc + 2, 4'b0001, 4'b0, 3'd0);
      repeat (16) tick();
      chk("to_before_fsel", 32'(fsel), 0);
      chk("to_before_flag", 32'(timeout), 0);
      tick();
`ifdef FDA_TIMEOUT_EN
      chk("to_fsel", 32'(fsel), 5);
      chk("to_flag", 32'(timeout), 1);
      pulse_wrap(0, 1'b1, 4'b0001, 3'd5);
      chk("to_sticky", 32'(timeout), 1);
`else
      chk("to_wait_fsel", 32'(fsel), 0);
      chk("to_wait_busy", 32'(busy), 1);
      pulse_wrap(0, 1'b0, 4'b0, 3'd0);
      chk("to_wrap_fsel", 32'(fsel), 5);
      pulse_wrap(0, 1'b1, 4'b0001, 3'd5);
      chk("to_flag_off", 32'(timeout), 0);
`endif
      req = 4'b0;
      repeat (4) tick();

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pending_events: got %0d left, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
